pmem_arbiter: RTL and testbench

//  Shares the single physical-memory port between the L2 demand path (read/write) and the

---
 rtl/pmem_arbiter_pkg.sv | 15 +
 rtl/arb_starve_counter.sv | 30 +++
 rtl/pmem_arbiter.sv | 126 ++++++++++++
 tb/tb_pmem_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pmem_arbiter_pkg.sv
// Shared types for the physical-memory arbiter: block bus type and arbiter FSM states.
package pmem_arbiter_pkg;

    typedef logic [255:0] lc3b_block;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEM_RD,
        ST_DEM_WR,
        ST_PF_RD,
        ST_PF_DROP,
        ST_TURN
    } pmem_arb_state_t;

endpackage

// File: rtl/arb_starve_counter.sv
// Counts demand grants issued while a prefetch is waiting; flags when prefetch must be forced.
module arb_starve_counter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic starve
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && cnt != LIMIT) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign starve = (cnt == LIMIT);

endmodule

// File: rtl/pmem_arbiter.sv
// Shares the pmem port between L2 demand traffic and prefetch line fills: demand priority,
// non-preemptive, with a starvation guard that forces a prefetch after repeated demand grants.
module pmem_arbiter
    import pmem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dem_read,
    input  logic        dem_write,
    input  logic [15:0] dem_address,
    input  lc3b_block   dem_wdata,
    output lc3b_block   dem_rdata,
    output logic        dem_resp,
    input  logic        pf_read,
    input  logic [15:0] pf_address,
    input  logic        pf_cancel,
    output lc3b_block   pf_rdata,
    output logic        pf_resp,
    output logic        pmem_read,
    output logic        pmem_write,
    output logic [15:0] pmem_address,
    output lc3b_block   pmem_wdata,
    input  lc3b_block   pmem_rdata,
    input  logic        pmem_resp,
    output logic        busy
);

    pmem_arb_state_t state_q, state_d;
    logic [15:0]     addr_q, addr_d;
    lc3b_block       wdata_q, wdata_d;
    logic            dem_grant, pf_grant, starve, pf_ok;

    assign pf_ok = pf_read && !pf_cancel;

    arb_starve_counter #(
        .STARVE_LIMIT(STARVE_LIMIT),
        .CNT_W       (CNT_W)
    ) u_starve (
        .clk   (clk),
        .reset (reset),
        .inc   (dem_grant && pf_read),
        .clr   (pf_grant || (state_q == ST_IDLE && !pf_read)),
        .starve(starve)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        dem_grant  = 1'b0;
        pf_grant   = 1'b0;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        dem_resp   = 1'b0;
        pf_resp    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (starve && pf_ok) begin
                    state_d  = ST_PF_RD;
                    addr_d   = pf_address;
                    pf_grant = 1'b1;
                end else if (dem_write) begin
                    state_d   = ST_DEM_WR;
                    addr_d    = dem_address;
                    wdata_d   = dem_wdata;
                    dem_grant = 1'b1;
                end else if (dem_read) begin
                    state_d   = ST_DEM_RD;
                    addr_d    = dem_address;
                    dem_grant = 1'b1;
                end else if (pf_ok) begin
                    state_d  = ST_PF_RD;
                    addr_d   = pf_address;
                    pf_grant = 1'b1;
                end
            end
            ST_DEM_RD, ST_DEM_WR: begin
                pmem_read  = (state_q == ST_DEM_RD);
                pmem_write = (state_q == ST_DEM_WR);
                if (pmem_resp) begin
                    dem_resp = 1'b1;
                    state_d  = ST_TURN;
                end
            end
            ST_PF_RD: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    pf_resp = !pf_cancel;
                    state_d = ST_TURN;
                end else if (pf_cancel) begin
                    state_d = ST_PF_DROP;
                end
            end
            // pmem cannot abort a read, so a cancelled fill runs to completion and is discarded.
            ST_PF_DROP: begin
                pmem_read = 1'b1;
                if (pmem_resp) state_d = ST_TURN;
            end
            ST_TURN: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;
    assign dem_rdata    = pmem_rdata;
    assign pf_rdata     = pmem_rdata;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter with a latency-programmable pmem responder model.
module tb_pmem_arbiter;
    import pmem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        dem_read = 1'b0, dem_write = 1'b0;
    logic [15:0] dem_address = '0;
    lc3b_block   dem_wdata = '0;
    lc3b_block   dem_rdata;
    logic        dem_resp;
    logic        pf_read = 1'b0, pf_cancel = 1'b0;
    logic [15:0] pf_address = '0;
    lc3b_block   pf_rdata;
    logic        pf_resp;
    logic        pmem_read, pmem_write;
    logic [15:0] pmem_address;
    lc3b_block   pmem_wdata;
    lc3b_block   pmem_rdata = '0;
    logic        pmem_resp = 1'b0;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int lat = 3;
    int req_cnt = 0;

    pmem_arbiter dut (
        .clk(clk), .reset(reset),
        .dem_read(dem_read), .dem_write(dem_write), .dem_address(dem_address),
        .dem_wdata(dem_wdata), .dem_rdata(dem_rdata), .dem_resp(dem_resp),
        .pf_read(pf_read), .pf_address(pf_address), .pf_cancel(pf_cancel),
        .pf_rdata(pf_rdata), .pf_resp(pf_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // pmem model: responds on the lat-th cycle of a request, data = address replicated.
    always @(posedge clk) begin
        #1;
        if (reset) begin
            req_cnt   = 0;
            pmem_resp = 1'b0;
        end else if (pmem_read || pmem_write) begin
            req_cnt++;
            pmem_resp = (req_cnt == lat);
            if (req_cnt == lat) pmem_rdata = {16{pmem_address}};
        end else begin
            req_cnt   = 0;
            pmem_resp = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Call at an IDLE negedge after driving the request; follows one transaction to its response.
    task automatic observe_txn(input string tag, input logic exp_wr, input logic [15:0] exp_addr,
                               input lc3b_block exp_wdata, input logic exp_dem, input int exp_len,
                               input logic scramble);
        int   len = 0;
        logic done = 1'b0, addr_ok = 1'b1, dir_ok = 1'b1, wdata_ok = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (pmem_read || pmem_write) begin
                len++;
                if (pmem_address !== exp_addr) addr_ok = 1'b0;
                if (pmem_write !== exp_wr || pmem_read !== !exp_wr) dir_ok = 1'b0;
                if (exp_wr && pmem_wdata !== exp_wdata) wdata_ok = 1'b0;
            end
            if (scramble) begin
                dem_address = ~exp_addr;
                dem_wdata   = ~exp_wdata;
            end
            if (dem_resp || pf_resp) begin
                done = 1'b1;
                check({tag, "_owner"}, {dem_resp, pf_resp}, exp_dem ? 2'b10 : 2'b01);
                if (!exp_wr)
                    check({tag, "_rdata"}, exp_dem ? dem_rdata : pf_rdata, {16{exp_addr}});
                if (exp_dem) begin
                    dem_read  = 1'b0;
                    dem_write = 1'b0;
                end else begin
                    pf_read = 1'b0;
                end
            end
        end
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_len"}, len, exp_len);
        check({tag, "_addr"}, addr_ok, 1'b1);
        check({tag, "_dir"}, dir_ok, 1'b1);
        check({tag, "_wdata"}, wdata_ok, 1'b1);
    endtask

    // From the response negedge: one TURN cycle, then back in IDLE.
    task automatic check_turn(input string tag);
        @(negedge clk);
        check({tag, "_turn_busy"}, busy, 1'b1);
        check({tag, "_turn_req"}, {pmem_read, pmem_write}, 2'b00);
        @(negedge clk);
        check({tag, "_idle_busy"}, busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        lc3b_block wd;
        int        dem_len, pf_seen, pf_resp_seen;

        repeat (2) @(negedge clk);
        check("rst_outs", {pmem_read, pmem_write, dem_resp, pf_resp, busy}, 5'b0);
        check("rst_addr", pmem_address, 16'h0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 1'b0);

        // 1: demand read, latency 3
        lat = 3;
        dem_address = 16'h1230;
        dem_read    = 1'b1;
        observe_txn("t1", 1'b0, 16'h1230, '0, 1'b1, 3, 1'b0);
        check_turn("t1");

        // 2: write and prefetch requested together; write first, then the prefetch
        wd = {8{32'hDEAD_BEEF}};
        dem_address = 16'h4440;
        dem_wdata   = wd;
        dem_write   = 1'b1;
        pf_address  = 16'h5550;
        pf_read     = 1'b1;
        observe_txn("t2w", 1'b1, 16'h4440, wd, 1'b1, 3, 1'b1);
        check_turn("t2w");
        observe_txn("t2p", 1'b0, 16'h5550, '0, 1'b0, 3, 1'b0);
        check_turn("t2p");

        // 3: prefetch starved by continuous demand reads; 5th grant is the prefetch
        lat = 2;
        pf_address  = 16'h6660;
        pf_read     = 1'b1;
        dem_address = 16'h7770;
        dem_read    = 1'b1;
        dem_len = 0;
        for (int g = 0; g < 4; g++) begin
            observe_txn("t3d", 1'b0, 16'h7770, '0, 1'b1, 2, 1'b0);
            dem_len++;
            @(negedge clk);
            dem_read = 1'b1;
            @(negedge clk);
        end
        check("t3_dem_grants", dem_len, 4);
        observe_txn("t3p", 1'b0, 16'h6660, '0, 1'b0, 2, 1'b0);
        check_turn("t3p");
        dem_read = 1'b0;
        @(negedge clk);

        // 4a: pf_cancel in IDLE blocks that cycle's prefetch grant
        pf_address = 16'h8880;
        pf_read    = 1'b1;
        pf_cancel  = 1'b1;
        @(negedge clk);
        check("t4_idle_cancel", busy, 1'b0);
        pf_cancel = 1'b0;

        // 4b: cancel one cycle into PF_RD; read held until pmem_resp, no pf_resp
        lat = 4;
        @(negedge clk);
        check("t4_pf_granted", pmem_read, 1'b1);
        pf_cancel = 1'b1;
        pf_seen = 1;
        pf_resp_seen = 0;
        @(negedge clk);
        pf_cancel = 1'b0;
        pf_read   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (pmem_read) pf_seen++;
            if (pf_resp) pf_resp_seen++;
            if (pmem_resp) break;
            @(negedge clk);
        end
        check("t4_read_len", pf_seen, 4);
        check("t4_no_pf_resp", pf_resp_seen, 0);
        check_turn("t4");

        // 5: demand address changes mid-read; pmem_address stays latched
        lat = 4;
        dem_address = 16'hABC0;
        dem_read    = 1'b1;
        observe_txn("t5", 1'b0, 16'hABC0, '0, 1'b1, 4, 1'b1);
        check_turn("t5");

        // 6: reset mid DEM_WR
        lat = 5;
        dem_address = 16'h9990;
        dem_wdata   = {8{32'h1234_5678}};
        dem_write   = 1'b1;
        @(negedge clk);
        check("t6_wr_active", pmem_write, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("t6_rst_outs", {pmem_write, busy, dem_resp}, 3'b000);
        dem_write = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("t6_idle", {busy, pmem_read, pmem_write}, 3'b000);
        check("t6_addr_cleared", pmem_address, 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
